// File: rtl/button_emulator.sv
// ============================================================================
// Module   : button_emulator
// Purpose  : Emulates press/release cycles on two push-button lines, with a
//            one-entry request buffer. Define CHATTER_EMU_EN to add
//            contact-bounce chatter around each press.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_emulator #(
    parameter int HOLD_CYCLES   = 40,
    parameter int GAP_CYCLES    = 40,
    parameter int BOUNCE_PHASES = 4,
    parameter int BOUNCE_PERIOD = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic sel,
    output logic btn0,
    output logic btn1,
    output logic busy,
    output logic done,
    output logic drop
);

    generate
        if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255 ||
            GAP_CYCLES < 1 || GAP_CYCLES > 255 ||
            BOUNCE_PHASES < 2 || BOUNCE_PHASES > 16 || (BOUNCE_PHASES % 2) != 0 ||
            BOUNCE_PERIOD < 1 || BOUNCE_PERIOD > 15) begin : g_bad_params
            $error("button_emulator: parameter out of legal range");
        end
    endgenerate

    localparam logic [7:0] c_HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] c_GAP_LAST  = 8'(GAP_CYCLES - 1);

`ifdef CHATTER_EMU_EN
    localparam logic [7:0] c_PH_LAST  = 8'(BOUNCE_PHASES - 1);
    localparam logic [3:0] c_PER_LAST = 4'(BOUNCE_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        BOUNCE_ON  = 3'd1,
        HOLD       = 3'd2,
        BOUNCE_OFF = 3'd3,
        GAP        = 3'd4
    } state_t;

    localparam state_t c_FIRST     = BOUNCE_ON;
    localparam state_t c_POST_HOLD = BOUNCE_OFF;

    logic [3:0] sub_q, sub_d;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HOLD = 3'd2,
        GAP  = 3'd4
    } state_t;

    localparam state_t c_FIRST     = HOLD;
    localparam state_t c_POST_HOLD = GAP;
`endif

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       sel_q, sel_d;
    logic       pend_v_q, pend_v_d;
    logic       pend_sel_q, pend_sel_d;
    logic       drop_d;
    logic       btn0_q, btn1_q, busy_q, done_q, drop_q;
    logic       w_gap_last;
    logic       w_start;
    logic       w_start_sel;
    logic       w_level;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        pend_v_d    = pend_v_q;
        pend_sel_d  = pend_sel_q;
        drop_d      = 1'b0;
        w_start     = 1'b0;
        w_start_sel = 1'b0;
        w_level     = 1'b0;
`ifdef CHATTER_EMU_EN
        sub_d       = sub_q;
`endif
        w_gap_last  = (state_q == GAP) && (cnt_q == c_GAP_LAST);

        // A consumed buffer is refilled by a same-cycle request instead of dropping it.
        if (pend_v_q && (state_q == IDLE || w_gap_last)) begin
            w_start     = 1'b1;
            w_start_sel = pend_sel_q;
            pend_v_d    = req;
            if (req) pend_sel_d = sel;
        end else if (req && state_q == IDLE) begin
            w_start     = 1'b1;
            w_start_sel = sel;
        end else if (req) begin
            if (!pend_v_q) begin
                pend_v_d   = 1'b1;
                pend_sel_d = sel;
            end else begin
                drop_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: ;
`ifdef CHATTER_EMU_EN
            BOUNCE_ON, BOUNCE_OFF: begin
                if (sub_q == c_PER_LAST) begin
                    sub_d = 4'd0;
                    if (cnt_q == c_PH_LAST) begin
                        state_d = (state_q == BOUNCE_ON) ? HOLD : GAP;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    sub_d = sub_q + 4'd1;
                end
            end
`endif
            HOLD: begin
                if (cnt_q == c_HOLD_LAST) begin
                    state_d = c_POST_HOLD;
                    cnt_d   = 8'd0;
`ifdef CHATTER_EMU_EN
                    sub_d   = 4'd0;
`endif
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            GAP: begin
                if (w_gap_last) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        if (w_start) begin
            state_d = c_FIRST;
            cnt_d   = 8'd0;
            sel_d   = w_start_sel;
`ifdef CHATTER_EMU_EN
            sub_d   = 4'd0;
`endif
        end

        // Rising chatter begins high, falling chatter begins low.
        case (state_d)
            HOLD:       w_level = 1'b1;
`ifdef CHATTER_EMU_EN
            BOUNCE_ON:  w_level = ~cnt_d[0];
            BOUNCE_OFF: w_level = cnt_d[0];
`endif
            default:    w_level = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            sel_q      <= 1'b0;
            pend_v_q   <= 1'b0;
            pend_sel_q <= 1'b0;
            btn0_q     <= 1'b0;
            btn1_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            drop_q     <= 1'b0;
`ifdef CHATTER_EMU_EN
            sub_q      <= 4'd0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            pend_v_q   <= pend_v_d;
            pend_sel_q <= pend_sel_d;
            btn0_q     <= w_level & ~sel_d;
            btn1_q     <= w_level & sel_d;
            busy_q     <= (state_d != IDLE);
            done_q     <= (state_d == GAP) && (cnt_d == c_GAP_LAST);
            drop_q     <= drop_d;
`ifdef CHATTER_EMU_EN
            sub_q      <= sub_d;
`endif
        end
    end

    assign btn0 = btn0_q;
    assign btn1 = btn1_q;
    assign busy = busy_q;
    assign done = done_q;
    assign drop = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_button_emulator.sv
// ============================================================================
// Module   : tb_button_emulator
// Purpose  : Directed self-checking bench for button_emulator (default params).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_emulator;

`ifdef CHATTER_EMU_EN
    localparam int L = 96;
`else
    localparam int L = 80;
`endif

    logic clk = 1'b0;
    logic reset, req, sel;
    logic btn0, btn1, busy, done, drop;
    int   n_cmp = 0;
    int   n_bad = 0;

    button_emulator dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .sel   (sel),
        .btn0  (btn0),
        .btn1  (btn1),
        .busy  (busy),
        .done  (done),
        .drop  (drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got {btn0,btn1,busy,done,drop}=%b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected button level k cycles into a press (k=1 is the first cycle).
    function automatic logic lvl(int k);
`ifdef CHATTER_EMU_EN
        if (k >= 1 && k <= 8)   return ((k - 1) / 2) % 2 == 0;
        if (k >= 9 && k <= 48)  return 1'b1;
        if (k >= 49 && k <= 56) return ((k - 49) / 2) % 2 == 1;
        return 1'b0;
`else
        return (k >= 1 && k <= 40);
`endif
    endfunction

    function automatic logic [4:0] exp_out(int id, int c);
        logic b0 = 1'b0, b1 = 1'b0, bz = 1'b0, dn = 1'b0, dr = 1'b0;
        case (id)
            1: begin
                b0 = lvl(c);
                bz = (c >= 1 && c <= L);
                dn = (c == L);
            end
            2, 3: begin
                b0 = lvl(c);
                b1 = lvl(c - L);
                bz = (c >= 1 && c <= 2 * L);
                dn = (c == L || c == 2 * L);
                dr = (id == 3 && c == 7);
            end
            4: begin
                if (c <= 20) begin
                    b0 = lvl(c);
                    bz = (c >= 1);
                end else begin
                    b0 = lvl(c - 30);
                    bz = (c >= 31 && c <= 30 + L);
                    dn = (c == 30 + L);
                end
            end
            6: begin
                b0 = lvl(c);
                b1 = lvl(c - L - 1);
                bz = (c >= 1 && c <= L) || (c >= L + 2 && c <= 2 * L + 1);
                dn = (c == L || c == 2 * L + 1);
            end
            default: ;
        endcase
        return {b0, b1, bz, dn, dr};
    endfunction

    function automatic logic req_at(int id, int c);
        case (id)
            1:       return c == 0;
            2:       return c == 0 || c == 5;
            3:       return c == 0 || c == 5 || c == 6;
            4:       return c == 0 || c == 30;
            6:       return c == 0 || c == L;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic sel_at(int id, int c);
        if ((id == 2 || id == 3) && c == 5) return 1'b1;
        if (id == 6 && c == L) return 1'b1;
        return 1'b0;
    endfunction

    task automatic run_scn(input int id, input int ncyc);
        for (int c = 0; c <= ncyc; c++) begin
            chk($sformatf("s%0d_c%0d", id, c), {btn0, btn1, busy, done, drop}, exp_out(id, c));
            if (id == 4 && c == 20) begin
                reset = 1'b1;
                #1;
                chk("s4_reset_immediate", {btn0, btn1, busy, done, drop}, 5'b00000);
                reset = 1'b0;
            end
            req = req_at(id, c);
            sel = sel_at(id, c);
            tick();
        end
        req = 1'b0;
        sel = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        reset = 1'b1;
        req   = 1'b1;
        sel   = 1'b1;
        repeat (3) tick();
        chk("reset_state", {btn0, btn1, busy, done, drop}, 5'b00000);
        reset = 1'b0;
        req   = 1'b0;
        sel   = 1'b0;
        tick();
        chk("after_release", {btn0, btn1, busy, done, drop}, 5'b00000);
        tick();

        run_scn(1, L + 5);
        run_scn(2, 2 * L + 5);
        run_scn(3, 2 * L + 5);
        run_scn(4, 30 + L + 5);
        run_scn(6, 2 * L + 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
